// File: rtl/matmul_sequencer.sv
// Control sequencer for an N x N systolic matrix multiply: loads operands into
// weight memory under a stallable handshake, then steps the feed/compute phase.
module matmul_sequencer #(
  parameter int unsigned N  = 2,
  localparam int unsigned AW = $clog2(2 * N * N),
  localparam int unsigned CW = $clog2(N * N + N),
  localparam int unsigned OW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          reuse_weights,
  input  logic          host_valid,
  output logic          host_req_mat,
  output logic          wm_load_mat,
  output logic [AW-1:0] wm_addr,
  output logic          feeding_en,
  output logic [CW-1:0] mmu_cycles,
  output logic          out_valid,
  output logic [OW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  localparam int unsigned NN = N * N;
  localparam logic [AW-1:0] LAST_A    = AW'(NN - 1);
  localparam logic [AW-1:0] LAST_AB   = AW'(2 * NN - 1);
  localparam logic [CW-1:0] FEED_LAST = CW'(NN + N - 1);
  localparam logic [CW-1:0] FIRST_OUT = CW'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FEED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            reuse_q, reuse_d;
  logic            done_q, done_d;
  logic            accept;
  logic            last_accept;

  assign accept      = (state_q == LOAD) && host_valid;
  // Reuse keeps B resident, so the load ends after the A block.
  assign last_accept = accept && (ld_cnt_q == (reuse_q ? LAST_A : LAST_AB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ld_cnt_q <= '0;
      cyc_q    <= '0;
      reuse_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      cyc_q    <= cyc_d;
      reuse_q  <= reuse_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    cyc_d    = cyc_q;
    reuse_d  = reuse_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          reuse_d  = reuse_weights;
          ld_cnt_d = '0;
        end
      end
      LOAD: begin
        if (last_accept) begin
          state_d  = FEED;
          ld_cnt_d = '0;
          cyc_d    = '0;
        end else if (accept) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      FEED: begin
        if (cyc_q == FEED_LAST) begin
          state_d = IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host_req_mat = (state_q == LOAD);
    wm_load_mat  = accept;
    wm_addr      = (state_q == LOAD) ? ld_cnt_q : '0;
    feeding_en   = (state_q == FEED);
    mmu_cycles   = (state_q == FEED) ? cyc_q : '0;
    // Row-major emission at N + i*N + j always trails readiness at N + i + j.
    out_valid    = (state_q == FEED) && (cyc_q >= FIRST_OUT);
    out_idx      = out_valid ? OW'(cyc_q - FIRST_OUT) : '0;
    busy         = (state_q != IDLE);
    done         = done_q;
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Parametrised control sequencer for the N×N systolic matrix-multiply datapath. It is the generalised successor of the fixed 2×2 controller. It loads operand matrices from the host into weight memory under a valid/ready-style handshake with stall support. It then runs the MMU feed/compute phase and indexes the N·N staggered results, one per cycle, and can optionally reuse resident weights. It sits between the host interface, weight memory and the MMU feed/writeback logic.

## Interface
- N, default 2: array dimension (N ≥ 2); derived AW = clog2(2·N·N) address bits, CW = clog2(N·N+N) cycle-counter bits
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- reuse_weights  in  1  sampled with start: 1 = load A only, keep B resident
- host_valid  in  1  host presents one element this cycle
- host_req_mat  out  1  sequencer is accepting matrix elements (ready)
- wm_load_mat  out  1  weight-memory write strobe
- wm_addr  out  AW  weight-memory element address
- feeding_en  out  1  MMU feed/compute enable
- mmu_cycles  out  CW  cycle index within feed/compute phase
- out_valid  out  1  result element available this cycle
- out_idx  out  clog2(N·N)  row-major index i·N+j of the result
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse

## Operation
- One clock; reset is asynchronous and active-low (clk, rst_n).
- States: IDLE, LOAD, FEED. IDLE→LOAD on start; LOAD→FEED on the last accepted element; FEED→IDLE after the final output cycle.
- On start, register the load target: 2·N·N elements (A at addr 0..N·N−1, B at N·N..2N·N−1), or N·N elements (A only) when reuse_weights=1.
- LOAD: host_req_mat=1. Element counter ld_cnt starts at 0. In a cycle with host_valid=1, wm_load_mat=1 and wm_addr=ld_cnt, and ld_cnt increments at the edge. With host_valid=0, wm_load_mat=0 and ld_cnt holds (stall, unbounded). The accept with ld_cnt = target−1 moves to FEED.
- wm_load_mat and wm_addr are combinational from state, ld_cnt and host_valid. wm_addr=0 outside LOAD.
- FEED lasts exactly N·N+N cycles. feeding_en=1, and mmu_cycles counts 0..N·N+N−1.
- Result (i,j) is ready by cycle N+i+j. It is emitted at cycle N+i·N+j (always ≥ readiness).
- out_valid=1 iff FEED and mmu_cycles ≥ N. out_idx = mmu_cycles−N when valid, else 0.
- done=1 for exactly the first IDLE cycle after FEED.
- start during LOAD/FEED is ignored. start in the done cycle is accepted.
- host_valid outside LOAD is ignored: no write, no counter change.
- Reset (asynchronous, any state, mid-load included): state=IDLE, ld_cnt=0, mmu_cycles=0. All outputs go to 0: host_req_mat, wm_load_mat, wm_addr, feeding_en, out_valid, out_idx, busy, done.

## Timing
- start high at edge E0 → LOAD from E0. host_req_mat, busy high in the cycle after E0.
- Load with no stalls: 2·N·N cycles (N·N with reuse). FEED begins the cycle after the last accept.
- First result appears N cycles after FEED entry. Last result at FEED cycle N·N+N−1. done the next cycle.
- Total start→done, no stalls: 1 + 2N² + N² + N cycles (N=2: 15).
- mmu_cycles returns to 0 on FEED exit. ld_cnt returns to 0 on LOAD exit.

## Test plan
- N=2, reuse=0, host_valid always 1: start at cycle 0. Check host_req_mat cycles 1–8 with wm_addr 0..7, feeding_en cycles 9–14, out_valid cycles 11–14 with out_idx 0,1,2,3, and done at cycle 15 only.
- N=2, host_valid toggling 1,0,1,0…: wm_load_mat mirrors host_valid, wm_addr advances only on accepts, 8 writes total, and FEED starts after the 8th accept.
- N=2, reuse_weights=1: only addresses 0..3 are written (4 load cycles), followed by FEED of 6 cycles with the same output sequence.
- N=4: 32 loads, then FEED of 20 cycles. out_valid from mmu_cycles 4 to 19 with out_idx 0..15, then done.
- start held high through an entire operation: no restart until the done cycle, then LOAD re-entered immediately. host_valid pulses in IDLE/FEED cause no wm_load_mat.
- rst_n asserted mid-LOAD (after 3 accepts) and mid-FEED (mmu_cycles=3): all outputs 0 asynchronously. After release, a fresh start writes wm_addr from 0.
